// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the 4-digit common-anode seven-segment scanner.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Active-low anode enable for one digit position; position 0 is the rightmost digit.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Data and display signals between the display-source multiplexer and the scanner.
interface seven_seg_scan_if;
  logic [31:0] disp_num;
  logic [7:0]  point_in;
  logic [7:0]  blink_in;
  logic        page_sel;
  logic        page_auto;
  logic        blank;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        page;
  logic        frame_tick;

  modport master (
    output disp_num, point_in, blink_in, page_sel, page_auto, blank,
    input  an, seg, page, frame_tick
  );

  modport slave (
    input  disp_num, point_in, blink_in, page_sel, page_auto, blank,
    output an, seg, page, frame_tick
  );
endinterface

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex nibble to active-low segment pattern decoder.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[value];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit hex display driver with per-frame input snapshot,
// manual/automatic paging of the 32-bit word, decimal points and blinking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int SCAN_W  = 17,
  parameter int PAGE_W  = 8,
  parameter int BLINK_W = 6
) (
  input logic            clk,
  input logic            rst,
  seven_seg_scan_if.slave bus
);

  localparam int FRAME_W = (PAGE_W > BLINK_W) ? PAGE_W : BLINK_W;

  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [1:0]         idx_reg;
  logic [FRAME_W-1:0] frame_cnt_reg;
  logic [FRAME_W-1:0] frame_cnt_next;
  logic [31:0]        snap_num_reg;
  logic [7:0]         snap_pt_reg;
  logic [7:0]         snap_bl_reg;
  logic               page_reg;
  logic               page_next;
  logic [3:0]         an_reg;
  logic [3:0]         an_next;
  logic [7:0]         seg_reg;
  logic [7:0]         seg_next;
  logic               frame_tick_reg;

  logic               scan_wrap;
  logic               frame_end;
  logic [2:0]         nib;
  logic [3:0]         snap_nib [8];
  logic [6:0]         seg_pat;
  logic               blink_phase;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign snap_nib[gi] = snap_num_reg[4*gi +: 4];
    end
  endgenerate

  assign scan_wrap      = &scan_cnt_reg;
  assign frame_end      = scan_wrap && (idx_reg == 2'd3);
  assign frame_cnt_next = frame_cnt_reg + 1'b1;
  assign nib            = {page_reg, idx_reg};
  assign blink_phase    = frame_cnt_reg[BLINK_W-1];

  seven_seg_hex_decode u_hex_decode (
    .value (snap_nib[nib]),
    .seg_n (seg_pat)
  );

  // Page only moves on a frame boundary so a frame never mixes halves of the word.
  always_comb begin
    page_next = page_reg;
    if (frame_end) begin
      if (bus.page_auto) begin
        if (frame_cnt_next[PAGE_W-1:0] == '0)
          page_next = ~page_reg;
      end else begin
        page_next = bus.page_sel;
      end
    end
  end

  // Blanking only darkens the anodes; cathodes keep tracking the selected digit.
  always_comb begin
    an_next  = anode_sel(idx_reg);
    seg_next = {~snap_pt_reg[nib], seg_pat};
    if (bus.blank || (snap_bl_reg[nib] && blink_phase))
      an_next = 4'hF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_reg   <= '0;
      idx_reg        <= '0;
      frame_cnt_reg  <= '0;
      snap_num_reg   <= '0;
      snap_pt_reg    <= '0;
      snap_bl_reg    <= '0;
      page_reg       <= 1'b0;
      an_reg         <= 4'hF;
      seg_reg        <= {1'b1, SEG_BLANK};
      frame_tick_reg <= 1'b0;
    end else begin
      scan_cnt_reg   <= scan_cnt_reg + 1'b1;
      frame_tick_reg <= frame_end;
      page_reg       <= page_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      if (scan_wrap)
        idx_reg <= idx_reg + 2'd1;
      if (frame_end) begin
        snap_num_reg  <= bus.disp_num;
        snap_pt_reg   <= bus.point_in;
        snap_bl_reg   <= bus.blink_in;
        frame_cnt_reg <= frame_cnt_next;
      end
    end
  end

  assign bus.an         = an_reg;
  assign bus.seg        = seg_reg;
  assign bus.page       = page_reg;
  assign bus.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: cycle-level behavioural model plus
// hand-computed digit expectations, with randomized input traffic.
module tb_seven_seg_scan;

  localparam int SCAN_W      = 2;
  localparam int PAGE_W      = 2;
  localparam int BLINK_W     = 2;
  localparam int DWELL       = 1 << SCAN_W;
  localparam int FRAME_LEN   = 4 * DWELL;
  localparam int PAGE_FRAMES = 1 << PAGE_W;
  localparam int BLINK_HALF  = 1 << (BLINK_W - 1);

  logic clk;
  logic rst;
  seven_seg_scan_if bus ();

  seven_seg_scan #(.SCAN_W(SCAN_W), .PAGE_W(PAGE_W), .BLINK_W(BLINK_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Segment patterns straight from the digit table, dp cleared to 0 here.
  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Behavioural model: position in the frame derives from a plain cycle count.
  int         m_cyc;
  int         m_frames;
  logic [31:0] m_num;
  logic [7:0] m_pt;
  logic [7:0] m_bl;
  logic       m_page;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_tick;
  int         m_idx;
  int         m_nib;
  int         m_phase;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc    = 0;
      m_frames = 0;
      m_num    = 32'h0;
      m_pt     = 8'h0;
      m_bl     = 8'h0;
      m_page   = 1'b0;
      exp_an   = 4'hF;
      exp_seg  = 8'hFF;
      exp_tick = 1'b0;
    end else begin
      m_idx   = (m_cyc / DWELL) % 4;
      m_nib   = (m_page ? 4 : 0) + m_idx;
      m_phase = (m_frames / BLINK_HALF) % 2;
      exp_seg = {~m_pt[m_nib], hex_tab[(m_num >> (4 * m_nib)) & 32'hF]};
      if (bus.blank || (m_bl[m_nib] && m_phase == 1))
        exp_an = 4'hF;
      else
        exp_an = 4'hF ^ (4'b0001 << m_idx);
      exp_tick = ((m_cyc % FRAME_LEN) == FRAME_LEN - 1);
      if (exp_tick) begin
        m_num    = bus.disp_num;
        m_pt     = bus.point_in;
        m_bl     = bus.blink_in;
        m_frames = m_frames + 1;
        if (bus.page_auto) begin
          if (m_frames % PAGE_FRAMES == 0)
            m_page = ~m_page;
        end else begin
          m_page = bus.page_sel;
        end
      end
      m_cyc = m_cyc + 1;
    end
  end

  int tests;
  int fails;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic step();
    @(negedge clk);
    chk("an", 32'(bus.an), 32'(exp_an));
    chk("seg", 32'(bus.seg), 32'(exp_seg));
    chk("page", 32'(bus.page), 32'(m_page));
    chk("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
  endtask

  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN + 4 && !seen; i++) begin
      step();
      seen = bus.frame_tick;
    end
    chk("frame_tick_seen", 32'(seen), 32'd1);
  endtask

  // Starting on a frame_tick edge, check one whole frame against literal digits.
  task automatic check_frame(input string name, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] s [4];
    logic [3:0] a [4];
    s = '{s0, s1, s2, s3};
    a = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int k = 0; k < FRAME_LEN; k++) begin
      step();
      chk({name, "_seg"}, 32'(bus.seg), 32'(s[k / DWELL]));
      chk({name, "_an"}, 32'(bus.an), 32'(a[k / DWELL]));
    end
    $display("[TB] frame %s checked", name);
  endtask

  int   changes;
  int   last_change;
  int   dark_frames;
  logic prev_page;
  logic dark;
  logic ticked;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.disp_num  = 32'h12345678;
    bus.point_in  = 8'h00;
    bus.blink_in  = 8'h00;
    bus.page_sel  = 1'b0;
    bus.page_auto = 1'b0;
    bus.blank     = 1'b0;

    // Held in reset: everything dark.
    repeat (3) begin
      step();
      chk("rst_an", 32'(bus.an), 32'hF);
      chk("rst_seg", 32'(bus.seg), 32'hFF);
    end
    #2 rst = 1'b1;

    // First frame shows the zeroed snapshot.
    ticked = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN && !ticked; i++) begin
      step();
      if (bus.frame_tick) ticked = 1'b1;
      else chk("first_frame_seg", 32'(bus.seg), 32'hC0);
    end
    chk("first_tick_seen", 32'(ticked), 32'd1);
    check_frame("reset_12345678", 8'h80, 8'hF8, 8'h82, 8'h92);

    // Manual page 1.
    bus.page_sel = 1'b1;
    bus.disp_num = 32'hDEADBEEF;
    repeat (FRAME_LEN) step();
    chk("page_after_tick", 32'(bus.page), 32'd1);
    check_frame("page1_deadbeef", 8'hA1, 8'h88, 8'h86, 8'hA1);
    for (int k = 0; k < FRAME_LEN; k++) begin
      step();
      if (k == 5) bus.page_sel = 1'b0;
      chk("page_sel_midframe", 32'(bus.page), (k < FRAME_LEN - 1) ? 32'd1 : 32'd0);
    end
    $display("[TB] manual page select checked");

    // Auto page: exactly two toggles, four ticks apart, across eight boundaries.
    bus.page_auto = 1'b1;
    changes = 0;
    last_change = -1;
    prev_page = bus.page;
    for (int t = 0; t < 8; t++) begin
      bus.page_sel = 1'($urandom_range(0, 1));
      wait_tick();
      if (bus.page != prev_page) begin
        if (last_change >= 0) chk("auto_page_gap", 32'(t - last_change), 32'd4);
        changes++;
        last_change = t;
      end
      prev_page = bus.page;
    end
    chk("auto_page_toggles", 32'(changes), 32'd2);
    $display("[TB] auto page: %0d toggles over 8 frames", changes);

    // Tear-free snapshot.
    bus.page_auto = 1'b0;
    bus.page_sel  = 1'b0;
    bus.disp_num  = 32'h0;
    wait_tick();
    wait_tick();
    repeat (DWELL) step();
    bus.disp_num = 32'h0000FFFF;
    for (int k = DWELL; k < FRAME_LEN; k++) begin
      step();
      chk("tear_free_seg", 32'(bus.seg), 32'hC0);
    end
    chk("tear_free_tick", 32'(bus.frame_tick), 32'd1);
    check_frame("all_f", 8'h8E, 8'h8E, 8'h8E, 8'h8E);

    // Decimal point on digit 0, blink on digit 1.
    bus.disp_num = 32'h0;
    bus.point_in = 8'h01;
    bus.blink_in = 8'h02;
    wait_tick();
    dark_frames = 0;
    for (int f = 0; f < 4; f++) begin
      dark = 1'b0;
      for (int k = 0; k < FRAME_LEN; k++) begin
        step();
        if (k < DWELL) chk("dp0_lit", 32'(bus.seg[7]), 32'd0);
        if (k >= DWELL && k < 2 * DWELL && bus.an == 4'hF) dark = 1'b1;
      end
      if (dark) dark_frames++;
    end
    chk("blink_dark_frames", 32'(dark_frames), 32'd2);
    $display("[TB] point/blink: %0d of 4 frames dark on digit 1", dark_frames);

    // Blank takes effect on the very next clock.
    for (int t = 0; t < 4; t++) begin
      repeat ($urandom_range(0, 20)) step();
      bus.blank = 1'b1;
      step();
      chk("blank_an", 32'(bus.an), 32'hF);
      step();
      bus.blank = 1'b0;
    end
    $display("[TB] blank checked");

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(0, 7) == 0) bus.disp_num = $urandom;
      if ($urandom_range(0, 7) == 0) bus.point_in = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus.blink_in = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus.page_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) bus.page_auto = ~bus.page_auto;
      if ($urandom_range(0, 15) == 0) bus.blank = ~bus.blank;
    end
    $display("[TB] random traffic: 1500 cycles");

    // Asynchronous reset pulse between clock edges, starting from page 1.
    bus.page_auto = 1'b0;
    bus.page_sel  = 1'b1;
    bus.blank     = 1'b0;
    wait_tick();
    chk("pre_reset_page", 32'(bus.page), 32'd1);
    repeat (5) step();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_an", 32'(bus.an), 32'hF);
    chk("async_rst_seg", 32'(bus.seg), 32'hFF);
    chk("async_rst_page", 32'(bus.page), 32'd0);
    chk("async_rst_tick", 32'(bus.frame_tick), 32'd0);
    #2 rst = 1'b1;
    repeat (3 * FRAME_LEN) step();
    $display("[TB] async reset checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Downstream consumer of the display-source multiplexer's 32-bit disp_num word; drives the Nexys3 4-digit common-anode 7-segment display.
- Time-multiplexes four hex digits with a free-running refresh counter.
- Shows either the lower or upper 16 bits ("page"), selected manually or toggled automatically.
- Snapshots its inputs once per frame so the display never tears mid-scan; supports per-digit decimal points and blinking.

Parameters:
SCAN_W, 17, width of the per-digit dwell counter; dwell = 2^SCAN_W clk cycles (1.31 ms at 100 MHz)
PAGE_W, 8, auto-page period = 2^PAGE_W frames
BLINK_W, 6, blink half-period = 2^(BLINK_W-1) frames (blink phase = MSB of frame counter bits [BLINK_W-1:0])

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
disp_num  in  32  hex word to display (8 nibbles; nibble k = bits [4k+3:4k])
point_in  in  8  decimal point enable per nibble position, 1 = lit
blink_in  in  8  blink enable per nibble position, 1 = blink
page_sel  in  1  manual page: 0 = nibbles 0-3, 1 = nibbles 4-7
page_auto  in  1  1 = page toggles automatically, page_sel ignored
blank  in  1  1 = all digits dark
an  out  4  anode enables, active-low, an[0] = rightmost digit
seg  out  8  cathodes, active-low, {dp,g,f,e,d,c,b,a}
page  out  1  page currently displayed
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-low. All state is cleared when rst = 0, independent of clk.
- Reset values:
  - an = 4'b1111, seg = 8'hFF, page = 0, frame_tick = 0.
  - scan_cnt, idx, frame_cnt, snap_num, snap_pt and snap_bl all = 0.
- scan_cnt (SCAN_W bits):
  - Increments every clk and wraps naturally.
  - When scan_cnt == all-ones: idx (2 bits) increments, wrapping 3 -> 0.
- Frame boundary: scan_cnt all-ones AND idx == 3. On that cycle:
  - snap_num <= disp_num, snap_pt <= point_in, snap_bl <= blink_in.
  - frame_cnt (max(PAGE_W,BLINK_W) bits) increments and wraps.
  - frame_tick = 1 on the following cycle only.
  - Page update:
    - If page_auto = 1, page toggles when frame_cnt[PAGE_W-1:0] wraps to 0.
    - Otherwise page <= page_sel.
  - disp_num, point_in and blink_in changes between boundaries are invisible until the next boundary.
  - page_sel changes take effect at a boundary only.
- Digit select: nib = {page, idx}; value = snap_num[4*nib +: 4], dp = snap_pt[nib], bl = snap_bl[nib].
- Outputs are registered and reflect the new idx 1 cycle after idx changes.
  - an = ~(4'b0001 << idx), except an = 4'b1111 when blank = 1 or (bl = 1 and blink phase = 1).
  - seg = {~dp, hex_to_seg(value)}.
  - seg still updates while the digit is dark; only an is forced high.
- hex_to_seg: active-low, {g..a}:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex)
- Simultaneous events:
  - A page_auto 1->0 transition at a boundary loads page_sel on that same boundary.
  - blank has priority over everything else and applies from the next cycle (registered), not frame-synchronous.
- Reset mid-scan: all outputs return immediately to their reset values. After release, the first frame shows 0000 on page 0 until the first boundary snapshot.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16-entry hex segment pattern constants.
  - The anode one-hot encoding function.
- One sub-module: seven_seg_hex_decode (combinational 4-bit -> 7-bit active-low decoder).
- All counters and the snapshot registers stay in the top level.

Test Plan:
All scenarios use SCAN_W=2, PAGE_W=2, BLINK_W=2.
- Reset check: hold rst=0 with disp_num=32'h12345678, then release. Required: an=1111 and seg=FF while rst=0. First frame shows 0 on every digit (seg=C0). After the first frame_tick, digits idx0..3 show 8,7,6,5 (seg 80,F8,82,92), with an cycling 1110,1101,1011,0111 at 4 clk each.
- Page select: page_auto=0, page_sel=1, disp_num=32'hDEADBEEF. Required: after the next boundary page=1 and digits idx0..3 show D,A,E,D (seg A1,88,86,A1). Toggling page_sel mid-frame has no effect until frame_tick.
- Auto page: page_auto=1. Required: page toggles exactly every 4 frame_ticks. page_sel changes have no effect.
- Tear-free snapshot: change disp_num from 32'h0000_0000 to 32'h0000_FFFF while idx=1. Required: digits 1-3 of the current frame still show 0. All digits show F (seg 8E) only after frame_tick.
- Point, blink and blank: point_in=8'h01, blink_in=8'h02, page 0. Required:
  - Digit 0 seg[7]=0.
  - Digit 1 an stays 1111 during blink-phase-1 frames and is lit otherwise.
  - Asserting blank forces an=1111 on the next clk in any frame.
- Async reset mid-operation: pulse rst=0 for 3 ns between clk edges during scanning. Required: an=1111, seg=FF and page=0 immediately, without waiting for a clk edge.
